// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle core controller: state encoding,
// pc_src / wb_sel selector values and op_flags bit positions.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_IMM = 2'd1;
  localparam logic [1:0] PC_SRC_ALU = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_UIMM = 2'd3;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam int         WD_WIDTH      = 10;

  localparam int OP_ALU_REG = 0;
  localparam int OP_ALU_IMM = 1;
  localparam int OP_BRANCH  = 2;
  localparam int OP_JALR    = 3;
  localparam int OP_JAL     = 4;
  localparam int OP_AUIPC   = 5;
  localparam int OP_LUI     = 6;
  localparam int OP_LOAD    = 7;
  localparam int OP_STORE   = 8;
  localparam int OP_SYSTEM  = 9;

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != '0) && ((v & (v - 10'd1)) == '0);
  endfunction

endpackage

// File: rtl/multicycle_controller_watchdog.sv
// Memory-wait watchdog: counts no-ready request cycles since the last entry
// into FETCH/MEM; expired flags that the next unacknowledged cycle is the last.
module mem_watchdog
  import multicycle_controller_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [WD_WIDTH-1:0] LAST = WD_WIDTH'(LIMIT - 1);

  logic [WD_WIDTH-1:0] cnt_q;

  // Saturates at LAST so a request left waiting cannot wrap the counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (count && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle core sequencer: drives memory, IR, PC and register-file
// controls from the current state and the decoded instruction.
//
// state     | meaning
// FETCH     | instruction read at PC, IR loads on mem_ready
// DECODE    | legality check, halt on System
// EXECUTE   | ALU operand select, branch resolution
// MEM       | data load/store at ALU address
// WRITEBACK | register write and PC update
// HALT      | absorbing, halted=1
// TRAP      | absorbing, illegal or bus_error set
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT_CYCLES = 255,
  parameter int HALT_ON_SYSTEM     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] op_flags,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic [1:0] mem_size,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic       illegal,
  output logic       bus_error,
  output logic [2:0] state
);

  state_t state_q, state_d;
  logic   set_illegal, set_bus_error;
  logic   wd_clear, wd_count, wd_expired, timeout;
  logic   decode_illegal;

  logic is_alu_reg, is_alu_imm, is_branch, is_jalr, is_jal;
  logic is_auipc, is_lui, is_load, is_store, is_system;

  assign is_alu_reg = op_flags[OP_ALU_REG];
  assign is_alu_imm = op_flags[OP_ALU_IMM];
  assign is_branch  = op_flags[OP_BRANCH];
  assign is_jalr    = op_flags[OP_JALR];
  assign is_jal     = op_flags[OP_JAL];
  assign is_auipc   = op_flags[OP_AUIPC];
  assign is_lui     = op_flags[OP_LUI];
  assign is_load    = op_flags[OP_LOAD];
  assign is_store   = op_flags[OP_STORE];
  assign is_system  = op_flags[OP_SYSTEM];

  assign decode_illegal = !is_onehot(op_flags)
                        || (is_load && (funct3 == 3'd3 || funct3[2:1] == 2'b11))
                        || (is_store && funct3 >= 3'd3)
                        || (is_branch && funct3[2:1] == 2'b01)
                        || (is_jalr && funct3 != 3'd0);

  assign wd_count = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
  assign wd_clear = (state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM);
  assign timeout  = wd_expired && !mem_ready;

  mem_watchdog #(.LIMIT(MEM_TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_HALT) halted    <= 1'b1;
      if (set_illegal)       illegal   <= 1'b1;
      if (set_bus_error)     bus_error <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    mem_size      = 2'b00;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = PC_SRC_PC4;
    alu_src_a     = 1'b0;
    alu_src_b     = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_size = MEM_SIZE_WORD;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_d       = S_TRAP;
        end
      end
      S_DECODE: begin
        if (decode_illegal) begin
          set_illegal = 1'b1;
          state_d     = S_TRAP;
        end else if (is_system && HALT_ON_SYSTEM != 0) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_src_a = is_auipc | is_jal;
        alu_src_b = is_alu_imm | is_load | is_store | is_jalr | is_auipc;
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? PC_SRC_IMM : PC_SRC_PC4;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_system) begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        mem_size     = funct3[1:0];
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_d       = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        if (is_load) begin
          wb_sel = WB_LOAD;
        end else if (is_jal) begin
          wb_sel = WB_PC4;
          pc_src = PC_SRC_IMM;
        end else if (is_jalr) begin
          wb_sel = WB_PC4;
          pc_src = PC_SRC_ALU;
        end else if (is_lui) begin
          wb_sel = WB_UIMM;
        end
      end
      default: ;
    endcase
    // A cycle under reset must not commit anything, even mid-access.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      mem_size     = 2'b00;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_SRC_PC4;
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      rf_we        = 1'b0;
      wb_sel       = WB_ALU;
    end
  end

  assign state = state_q;

  logic unused_ok;
  assign unused_ok = is_alu_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus
// hand sequences for watchdog timeout, reset mid-store and System handling.
module tb_multicycle_controller;

  localparam logic [9:0] ALUR  = 10'd1 << 0;
  localparam logic [9:0] ALUI  = 10'd1 << 1;
  localparam logic [9:0] BR    = 10'd1 << 2;
  localparam logic [9:0] JALR  = 10'd1 << 3;
  localparam logic [9:0] JAL   = 10'd1 << 4;
  localparam logic [9:0] AUIPC = 10'd1 << 5;
  localparam logic [9:0] LUI   = 10'd1 << 6;
  localparam logic [9:0] LOAD  = 10'd1 << 7;
  localparam logic [9:0] STORE = 10'd1 << 8;
  localparam logic [9:0] SYS   = 10'd1 << 9;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3;
  localparam logic [2:0] SW = 3'd4, SH = 3'd5, S_TR = 3'd6;

  // {mem_req, mem_we, mem_addr_sel, mem_size}
  localparam logic [4:0] M_OFF = 5'b0_0_0_00;
  localparam logic [4:0] M_F   = 5'b1_0_0_10;
  localparam logic [4:0] M_LW  = 5'b1_0_1_10;
  localparam logic [4:0] M_LB  = 5'b1_0_1_00;
  localparam logic [4:0] M_SW  = 5'b1_1_1_10;
  localparam logic [4:0] M_SB  = 5'b1_1_1_00;

  typedef struct packed {
    logic       rst;
    logic [9:0] op;
    logic [2:0] f3;
    logic       bt;
    logic       rdy;
    logic [2:0] st;
    logic [4:0] mem;
    logic       ir;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic [1:0] alu;
    logic       rf;
    logic [1:0] wb;
    logic [2:0] flg;
  } vec_t;

  logic       clk, reset, branch_taken, mem_ready;
  logic [9:0] op_flags;
  logic [2:0] funct3;

  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_src_a, alu_src_b, rf_we;
  logic       halted, illegal, bus_error;
  logic [1:0] mem_size, pc_src, wb_sel;
  logic [2:0] state;

  logic       n_mem_req, n_mem_we, n_mem_addr_sel, n_ir_we, n_pc_we, n_alu_src_a, n_alu_src_b, n_rf_we;
  logic       n_halted, n_illegal, n_bus_error;
  logic [1:0] n_mem_size, n_pc_src, n_wb_sel;
  logic [2:0] n_state;

  int   nvec = 0;
  int   nerr = 0;
  vec_t tbl[$];

  multicycle_controller #(.MEM_TIMEOUT_CYCLES(4), .HALT_ON_SYSTEM(1)) dut (
    .clk(clk), .reset(reset), .op_flags(op_flags), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .mem_size(mem_size),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted),
    .illegal(illegal), .bus_error(bus_error), .state(state)
  );

  multicycle_controller #(.MEM_TIMEOUT_CYCLES(4), .HALT_ON_SYSTEM(0)) dut_nop (
    .clk(clk), .reset(reset), .op_flags(op_flags), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr_sel(n_mem_addr_sel), .mem_size(n_mem_size),
    .ir_we(n_ir_we), .pc_we(n_pc_we), .pc_src(n_pc_src), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .rf_we(n_rf_we), .wb_sel(n_wb_sel), .halted(n_halted),
    .illegal(n_illegal), .bus_error(n_bus_error), .state(n_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic [9:0] op, input logic [2:0] f3,
                     input logic bt, input logic rdy, input logic [2:0] st,
                     input logic [4:0] mem, input logic ir, input logic pcwe,
                     input logic [1:0] pcsrc, input logic [1:0] alu, input logic rf,
                     input logic [1:0] wb, input logic [2:0] flg);
    vec_t v;
    v = '{rst, op, f3, bt, rdy, st, mem, ir, pcwe, pcsrc, alu, rf, wb, flg};
    tbl.push_back(v);
  endtask

  task automatic fetch(input logic [9:0] op, input logic [2:0] f3, input int waits);
    for (int k = 0; k < waits; k++)
      add(0, op, f3, 0, 0, SF, M_F, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000);
    add(0, op, f3, 0, 1, SF, M_F, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000);
  endtask

  task automatic dec(input logic [9:0] op, input logic [2:0] f3);
    add(0, op, f3, 0, 0, SD, M_OFF, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000);
  endtask

  task automatic step(input logic rst, input logic [9:0] op, input logic [2:0] f3,
                      input logic bt, input logic rdy);
    @(negedge clk);
    reset = rst; op_flags = op; funct3 = f3; branch_taken = bt; mem_ready = rdy;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] packed_out();
    return {state, mem_req, mem_we, mem_addr_sel, mem_size, ir_we, pc_we, pc_src,
            alu_src_a, alu_src_b, rf_we, wb_sel, halted, illegal, bus_error};
  endfunction

  logic [9:0] ill_op[10];
  logic [2:0] ill_f3[10];

  initial begin
    reset = 1'b1; op_flags = '0; funct3 = '0; branch_taken = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);

    add(1, '0, 0, 0, 0, SF, M_OFF, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000);
    // addi: 4 cycles
    fetch(ALUI, 0, 0); dec(ALUI, 0);
    add(0, ALUI, 0, 0, 0, SE, M_OFF, 0, 0, 2'd0, 2'b01, 0, 2'd0, 3'b000);
    add(0, ALUI, 0, 0, 0, SW, M_OFF, 0, 1, 2'd0, 2'b00, 1, 2'd0, 3'b000);
    // add, with stray mem_ready outside FETCH/MEM
    fetch(ALUR, 0, 1);
    add(0, ALUR, 0, 0, 1, SD, M_OFF, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, ALUR, 0, 0, 1, SE, M_OFF, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, ALUR, 0, 0, 0, SW, M_OFF, 0, 1, 2'd0, 2'b00, 1, 2'd0, 3'b000);
    // lw, MEM held 3 cycles
    fetch(LOAD, 2, 0); dec(LOAD, 2);
    add(0, LOAD, 2, 0, 0, SE, M_OFF, 0, 0, 2'd0, 2'b01, 0, 2'd0, 3'b000);
    add(0, LOAD, 2, 0, 0, SM, M_LW, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, LOAD, 2, 0, 0, SM, M_LW, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, LOAD, 2, 0, 1, SM, M_LW, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, LOAD, 2, 0, 0, SW, M_OFF, 0, 1, 2'd0, 2'b00, 1, 2'd1, 3'b000);
    // lb, ready arrives on the 4th MEM cycle (timeout boundary)
    fetch(LOAD, 0, 0); dec(LOAD, 0);
    add(0, LOAD, 0, 0, 0, SE, M_OFF, 0, 0, 2'd0, 2'b01, 0, 2'd0, 3'b000);
    for (int k = 0; k < 3; k++)
      add(0, LOAD, 0, 0, 0, SM, M_LB, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, LOAD, 0, 0, 1, SM, M_LB, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, LOAD, 0, 0, 0, SW, M_OFF, 0, 1, 2'd0, 2'b00, 1, 2'd1, 3'b000);
    // sb, fetch ready on 4th cycle
    fetch(STORE, 0, 3); dec(STORE, 0);
    add(0, STORE, 0, 0, 0, SE, M_OFF, 0, 0, 2'd0, 2'b01, 0, 2'd0, 3'b000);
    add(0, STORE, 0, 0, 1, SM, M_SB, 0, 1, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    // sw with two MEM waits
    fetch(STORE, 2, 0); dec(STORE, 2);
    add(0, STORE, 2, 0, 0, SE, M_OFF, 0, 0, 2'd0, 2'b01, 0, 2'd0, 3'b000);
    add(0, STORE, 2, 0, 0, SM, M_SW, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, STORE, 2, 0, 0, SM, M_SW, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, STORE, 2, 0, 1, SM, M_SW, 0, 1, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    // branches: beq taken, bne not taken, bgeu taken
    fetch(BR, 0, 2); dec(BR, 0);
    add(0, BR, 0, 1, 0, SE, M_OFF, 0, 1, 2'd1, 2'b00, 0, 2'd0, 3'b000);
    fetch(BR, 1, 0); dec(BR, 1);
    add(0, BR, 1, 0, 0, SE, M_OFF, 0, 1, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    fetch(BR, 7, 0); dec(BR, 7);
    add(0, BR, 7, 1, 0, SE, M_OFF, 0, 1, 2'd1, 2'b00, 0, 2'd0, 3'b000);
    // jal, jalr, lui, auipc
    fetch(JAL, 0, 0); dec(JAL, 0);
    add(0, JAL, 0, 0, 0, SE, M_OFF, 0, 0, 2'd0, 2'b10, 0, 2'd0, 3'b000);
    add(0, JAL, 0, 0, 0, SW, M_OFF, 0, 1, 2'd1, 2'b00, 1, 2'd2, 3'b000);
    fetch(JALR, 0, 0); dec(JALR, 0);
    add(0, JALR, 0, 0, 0, SE, M_OFF, 0, 0, 2'd0, 2'b01, 0, 2'd0, 3'b000);
    add(0, JALR, 0, 0, 0, SW, M_OFF, 0, 1, 2'd2, 2'b00, 1, 2'd2, 3'b000);
    fetch(LUI, 0, 1); dec(LUI, 0);
    add(0, LUI, 0, 0, 0, SE, M_OFF, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b000);
    add(0, LUI, 0, 0, 0, SW, M_OFF, 0, 1, 2'd0, 2'b00, 1, 2'd3, 3'b000);
    fetch(AUIPC, 0, 0); dec(AUIPC, 0);
    add(0, AUIPC, 0, 0, 0, SE, M_OFF, 0, 0, 2'd0, 2'b11, 0, 2'd0, 3'b000);
    add(0, AUIPC, 0, 0, 0, SW, M_OFF, 0, 1, 2'd0, 2'b00, 1, 2'd0, 3'b000);
    // op_flags=0: TRAP, ready pulses ignored, reset recovers
    fetch('0, 0, 0); dec('0, 0);
    add(0, '0, 0, 0, 1, S_TR, M_OFF, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b010);
    add(0, '0, 0, 0, 0, S_TR, M_OFF, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b010);
    add(1, '0, 0, 0, 1, S_TR, M_OFF, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b010);
    ill_op = '{LOAD, LOAD, LOAD, STORE, STORE, BR, BR, JALR, ALUR | ALUI, SYS | LUI};
    ill_f3 = '{3'd3, 3'd6, 3'd7, 3'd3, 3'd7, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0};
    for (int c = 0; c < 10; c++) begin
      fetch(ill_op[c], ill_f3[c], 0); dec(ill_op[c], ill_f3[c]);
      add(0, ill_op[c], ill_f3[c], 0, 1, S_TR, M_OFF, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b010);
      add(1, ill_op[c], ill_f3[c], 0, 0, S_TR, M_OFF, 0, 0, 2'd0, 2'b00, 0, 2'd0, 3'b010);
    end

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].bt, tbl[i].rdy);
      chk($sformatf("row%0d", i), 32'(packed_out()),
          32'({tbl[i].st, tbl[i].mem, tbl[i].ir, tbl[i].pcwe, tbl[i].pcsrc,
               tbl[i].alu, tbl[i].rf, tbl[i].wb, tbl[i].flg}));
    end

    // FETCH watchdog expiry after 4 unacknowledged cycles
    step(1, ALUR, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, ALUR, 0, 0, 0);
      chk("to_fetch_state", 32'(state), 32'(SF));
      chk("to_fetch_req", 32'(mem_req), 32'd1);
    end
    step(0, ALUR, 0, 0, 1);
    chk("to_trap_state", 32'(state), 32'(S_TR));
    chk("to_bus_error", 32'(bus_error), 32'd1);
    chk("to_illegal", 32'(illegal), 32'd0);
    chk("to_trap_ir_we", 32'(ir_we), 32'd0);
    chk("to_trap_req", 32'(mem_req), 32'd0);

    // MEM watchdog expiry on a stuck store
    step(1, STORE, 2, 0, 0);
    step(0, STORE, 2, 0, 1);
    step(0, STORE, 2, 0, 0);
    step(0, STORE, 2, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, STORE, 2, 0, 0);
      chk("mto_mem_state", 32'(state), 32'(SM));
      chk("mto_mem_we", 32'(mem_we), 32'd1);
    end
    step(0, STORE, 2, 0, 1);
    chk("mto_trap_state", 32'(state), 32'(S_TR));
    chk("mto_bus_error", 32'(bus_error), 32'd1);
    chk("mto_pc_we", 32'(pc_we), 32'd0);

    // reset mid-MEM of a store drops the access
    step(1, STORE, 2, 0, 0);
    step(0, STORE, 2, 0, 1);
    step(0, STORE, 2, 0, 0);
    step(0, STORE, 2, 0, 0);
    step(0, STORE, 2, 0, 0);
    chk("rst_mem_we_before", 32'(mem_we), 32'd1);
    step(1, STORE, 2, 0, 1);
    chk("rst_cycle_pc_we", 32'(pc_we), 32'd0);
    chk("rst_cycle_req", 32'(mem_req), 32'd0);
    step(0, STORE, 2, 0, 0);
    chk("rst_after_state", 32'(state), 32'(SF));
    chk("rst_after_mem_we", 32'(mem_we), 32'd0);
    chk("rst_after_pc_we", 32'(pc_we), 32'd0);
    chk("rst_after_flags", 32'({halted, illegal, bus_error}), 32'd0);
    step(0, STORE, 2, 0, 0);
    step(0, STORE, 2, 0, 0);
    step(0, STORE, 2, 0, 1);
    chk("rst_wd_cleared_ir_we", 32'(ir_we), 32'd1);
    step(0, STORE, 2, 0, 0);
    chk("rst_wd_cleared_state", 32'(state), 32'(SD));

    // System: halts one instance, NOP on the other
    step(1, SYS, 0, 0, 0);
    step(0, SYS, 0, 0, 1);
    chk("sys_ir_we", 32'({ir_we, n_ir_we}), 32'b11);
    step(0, SYS, 0, 0, 0);
    chk("sys_decode", 32'({state, n_state}), 32'({SD, SD}));
    step(0, SYS, 0, 0, 0);
    chk("sys_halt_state", 32'(state), 32'(SH));
    chk("sys_halted", 32'(halted), 32'd1);
    chk("sys_nop_state", 32'(n_state), 32'(SE));
    chk("sys_nop_pc", 32'({n_pc_we, n_pc_src, n_halted}), 32'({1'b1, 2'd0, 1'b0}));
    step(0, SYS, 0, 0, 1);
    chk("sys_halt_absorb", 32'({state, mem_req, pc_we, rf_we, ir_we}), 32'({SH, 4'b0000}));
    chk("sys_nop_fetch", 32'({n_state, n_mem_req, n_ir_we}), 32'({SF, 2'b11}));
    step(1, SYS, 0, 0, 0);
    step(0, ALUR, 0, 0, 0);
    chk("sys_reset_recover", 32'({state, halted}), 32'({SF, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
